// File: rtl/fma_arbiter_if.sv
// fma_arbiter_if
//   Bundles the requester-side and FMA-side signals of fma_arbiter.
//   Port i of every per-requester vector occupies the i-th slice
//   (32 bits for operands, 2 for opcode, 3 for rounding mode).
//   slave  : arbiter view (consumes requests, drives the FMA unit)
//   master : environment view (requesters plus the FMA unit)
interface fma_arbiter_if #(
   parameter int NUM_REQ = 4
);
   localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ*32-1:0] req_rs1;
   logic [NUM_REQ*32-1:0] req_rs2;
   logic [NUM_REQ*32-1:0] req_rs3;
   logic [NUM_REQ*2-1:0]  req_opcode;
   logic [NUM_REQ*3-1:0]  req_frm;
   logic [NUM_REQ-1:0]    resp_valid;
   logic [NUM_REQ-1:0]    resp_ready;
   logic [31:0]           resp_rd;
   logic                  resp_nx;
   logic                  resp_err;
   logic                  fma_start;
   logic [31:0]           fma_rs1;
   logic [31:0]           fma_rs2;
   logic [31:0]           fma_rs3;
   logic [1:0]            fma_opcode;
   logic [2:0]            fma_frm;
   logic [31:0]           fma_rd;
   logic                  fma_flag_nx;
   logic                  fma_done;
   logic                  busy;
   logic [IDW-1:0]        grant_id;

   modport slave (
      input  req_valid, req_rs1, req_rs2, req_rs3, req_opcode, req_frm,
      input  resp_ready, fma_rd, fma_flag_nx, fma_done,
      output req_ready, resp_valid, resp_rd, resp_nx, resp_err,
      output fma_start, fma_rs1, fma_rs2, fma_rs3, fma_opcode, fma_frm,
      output busy, grant_id
   );

   modport master (
      output req_valid, req_rs1, req_rs2, req_rs3, req_opcode, req_frm,
      output resp_ready, fma_rd, fma_flag_nx, fma_done,
      input  req_ready, resp_valid, resp_rd, resp_nx, resp_err,
      input  fma_start, fma_rs1, fma_rs2, fma_rs3, fma_opcode, fma_frm,
      input  busy, grant_id
   );
endinterface

// File: rtl/fma_arbiter.sv
// fma_arbiter
//   Round-robin arbiter/sequencer sharing one FMA unit among NUM_REQ
//   requesters. One operation at a time: IDLE accepts a request, ISSUE
//   pulses fma_start, WAIT waits for fma_done under a watchdog, RESP
//   presents the result to the owner over valid/ready.
// Ports
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : fma_arbiter_if.slave (requests, responses, FMA unit, status)
// Parameters
//   NUM_REQ : requesters (2..8), must match the interface
//   TIMEOUT : watchdog bound in cycles (>= 2)
module fma_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 64
) (
   input  logic          clk,
   input  logic          rst,
   fma_arbiter_if.slave  bus
);
   localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW  = $clog2(TIMEOUT) + 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t         state_q, state_d;
   logic [IDW-1:0] last_q, last_d;
   logic [IDW-1:0] owner_q, owner_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [31:0]    rs1_q, rs1_d, rs2_q, rs2_d, rs3_q, rs3_d;
   logic [1:0]     op_q, op_d;
   logic [2:0]     frm_q, frm_d;
   logic [31:0]    rd_q, rd_d;
   logic           nx_q, nx_d;
   logic           err_q, err_d;

   logic [IDW-1:0]     win;
   logic [IDW-1:0]     cand;
   logic               any_vld;
   int                 idx;
   logic [31:0]        sel_rs1, sel_rs2, sel_rs3;
   logic [1:0]         sel_op;
   logic [2:0]         sel_frm;
   logic               accept;
   logic               resp_ack;
   logic               start_c;
   logic [NUM_REQ-1:0] req_ready_c;
   logic [NUM_REQ-1:0] resp_valid_c;

   // Round-robin search: first valid port strictly after last_q, wrapping.
   always_comb begin
      win     = '0;
      cand    = '0;
      any_vld = 1'b0;
      idx     = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx  = (int'(last_q) + k) % NUM_REQ;
         cand = IDW'(idx);
         if (!any_vld && bus.req_valid[cand]) begin
            any_vld = 1'b1;
            win     = cand;
         end
      end
   end

   // Winner's operand slice.
   always_comb begin
      sel_rs1 = '0;
      sel_rs2 = '0;
      sel_rs3 = '0;
      sel_op  = '0;
      sel_frm = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win == IDW'(i)) begin
            sel_rs1 = bus.req_rs1[i*32 +: 32];
            sel_rs2 = bus.req_rs2[i*32 +: 32];
            sel_rs3 = bus.req_rs3[i*32 +: 32];
            sel_op  = bus.req_opcode[i*2 +: 2];
            sel_frm = bus.req_frm[i*3 +: 3];
         end
      end
   end

   assign accept = (state_q == S_IDLE) && any_vld;

   // Per-port handshakes. req_ready is masked while rst is held so that no
   // port sees an accept during reset even if its request is pending.
   always_comb begin
      req_ready_c  = '0;
      resp_valid_c = '0;
      resp_ack     = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (accept && !rst && (win == IDW'(i))) begin
            req_ready_c[i] = 1'b1;
         end
         if ((state_q == S_RESP) && (owner_q == IDW'(i))) begin
            resp_valid_c[i] = 1'b1;
            resp_ack        = bus.resp_ready[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         last_q  <= IDW'(NUM_REQ - 1);
         owner_q <= '0;
         cnt_q   <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         rs3_q   <= '0;
         op_q    <= '0;
         frm_q   <= '0;
         rd_q    <= '0;
         nx_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
         rs3_q   <= rs3_d;
         op_q    <= op_d;
         frm_q   <= frm_d;
         rd_q    <= rd_d;
         nx_q    <= nx_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      rs1_d   = rs1_q;
      rs2_d   = rs2_q;
      rs3_d   = rs3_q;
      op_d    = op_q;
      frm_d   = frm_q;
      rd_d    = rd_q;
      nx_d    = nx_q;
      err_d   = err_q;
      start_c = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (any_vld) begin
               rs1_d   = sel_rs1;
               rs2_d   = sel_rs2;
               rs3_d   = sel_rs3;
               op_d    = sel_op;
               frm_d   = sel_frm;
               owner_d = win;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            // fma_done is deliberately not looked at here: a level left
            // over from the previous operation must not complete this one.
            start_c = 1'b1;
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // Done has priority over the watchdog. The watchdog compares
            // against TIMEOUT-2 because cnt_q lags the incremented count by
            // one; this yields resp_valid TIMEOUT cycles after fma_start.
            if (bus.fma_done) begin
               rd_d    = bus.fma_rd;
               nx_d    = bus.fma_flag_nx;
               err_d   = 1'b0;
               state_d = S_RESP;
            end else if (cnt_q == CW'(TIMEOUT - 2)) begin
               rd_d    = 32'h7FC0_0000;
               nx_d    = 1'b0;
               err_d   = 1'b1;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_RESP: begin
            if (resp_ack) begin
               last_d  = owner_q;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.req_ready  = req_ready_c;
   assign bus.resp_valid = resp_valid_c;
   assign bus.resp_rd    = rd_q;
   assign bus.resp_nx    = nx_q;
   assign bus.resp_err   = err_q;
   assign bus.fma_start  = start_c;
   assign bus.fma_rs1    = rs1_q;
   assign bus.fma_rs2    = rs2_q;
   assign bus.fma_rs3    = rs3_q;
   assign bus.fma_opcode = op_q;
   assign bus.fma_frm    = frm_q;
   assign bus.busy       = (state_q != S_IDLE);
   assign bus.grant_id   = owner_q;
endmodule

// File: doc/fma_arbiter.md
# fma_arbiter

Round-robin arbiter and sequencer that shares one `fpu_fma` unit among `NUM_REQ` requesters, such as issue lanes or a vector sequencer. It accepts one request at a time and drives the unit's single-cycle `start` pulse. It then waits for `done`, with a watchdog, and routes the result and inexact flag back to the winning requester through a valid/ready response handshake.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 64: maximum cycles spent in WAIT before the watchdog fires. Must be ≥2.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  NUM_REQ  per-port request valid.
- `req_ready`  out  NUM_REQ  per-port accept, one-hot or zero.
- `req_rs1`, `req_rs2`, `req_rs3`  in  NUM_REQ*32 each  operands; port i occupies bits [32i+31:32i].
- `req_opcode`  in  NUM_REQ*2  FMA opcode per port.
- `req_frm`  in  NUM_REQ*3  rounding mode per port.
- `resp_valid`  out  NUM_REQ  per-port response valid, one-hot or zero.
- `resp_ready`  in  NUM_REQ  per-port response accept.
- `resp_rd`  out  32  result, shared by all ports.
- `resp_nx`  out  1  inexact flag, shared.
- `resp_err`  out  1  result came from the watchdog, not the FMA unit.
- `fma_start`  out  1  start pulse to the FMA unit.
- `fma_rs1`, `fma_rs2`, `fma_rs3`  out  32 each  operands to the FMA unit.
- `fma_opcode`  out  2  opcode to the FMA unit.
- `fma_frm`  out  3  rounding mode to the FMA unit.
- `fma_rd`  in  32  result from the FMA unit.
- `fma_flag_nx`  in  1  inexact flag from the FMA unit.
- `fma_done`  in  1  completion from the FMA unit.
- `busy`  out  1  high in any state other than IDLE.
- `grant_id`  out  $clog2(NUM_REQ)  index of the current owner.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT and RESP.
- **IDLE:**
  - If any `req_valid` is high, the winner is the first valid port searching upward from `last_grant+1`, wrapping modulo NUM_REQ.
  - `req_ready[winner]` = 1 combinationally in that cycle, and the request is accepted.
  - The winner's rs1/rs2/rs3/opcode/frm are registered into `fma_*`, `owner` is set to the winner, and the FSM goes to ISSUE.
  - With no valid request, the FSM stays in IDLE and `req_ready` = 0.
- **ISSUE:** `fma_start` = 1 for exactly this cycle. The FSM goes to WAIT and clears the watchdog counter.
- **WAIT:**
  - `fma_*` operands are held stable and the counter increments each cycle.
  - On `fma_done` = 1, `fma_rd` and `fma_flag_nx` are captured into `resp_rd` and `resp_nx`, `resp_err` is set to 0, and the FSM goes to RESP.
  - If the counter reaches TIMEOUT-1 with no done, the FSM instead captures `resp_rd` = 32'h7FC00000, `resp_nx` = 0, `resp_err` = 1, and goes to RESP.
  - If done and timeout occur in the same cycle, done wins.
- **RESP:**
  - `resp_valid[owner]` = 1, with `resp_rd`, `resp_nx` and `resp_err` held stable.
  - On `resp_ready[owner]` = 1, `last_grant` is set to `owner` and the FSM goes to IDLE.
  - `resp_ready` on other ports is ignored.
- `fma_done` is ignored outside WAIT, including a stale level still high from the previous operation during ISSUE.
- Requests arriving outside IDLE see `req_ready` = 0 and must hold. No request is dropped.
- The round-robin guarantees every continuously valid port is served within NUM_REQ grants.
- `grant_id` = `owner`. It is valid while `busy` = 1 and holds its last value in IDLE.

## Timing
- **Reset values:** state IDLE, `last_grant` = NUM_REQ-1 so that port 0 has first priority, and `owner` = 0.
  - All outputs are 0: `req_ready`, `resp_valid`, `resp_rd`, `resp_nx`, `resp_err`, `fma_start`, all `fma_*` operand/opcode/frm outputs, `busy` and `grant_id`.
- Reset asserted mid-operation aborts the operation immediately, with no response and no start. The FMA unit shares `rst`.
- **Latency:**
  - Request accepted at cycle T.
  - `fma_start` high at T+1.
  - With `fma_done` first sampled high at T+1+L (L ≥ 1), `resp_valid` rises at T+2+L.
  - With `resp_ready` already high, the FSM is in IDLE at T+3+L and can accept a new request there.
- Minimum issue-to-issue spacing is L+3 cycles.
- The watchdog path gives `resp_valid` at T+1+TIMEOUT.
- `req_ready` and `resp_valid` are never high in the same cycle for any port.

## Test plan
- **Single request.** Port 0 requests 2.0*3.0+4.0: rs1 = 40000000, rs2 = 40400000, rs3 = 40800000, opcode 00, frm 000.
  - Required: one `fma_start` pulse, then `resp_valid[0]` with `resp_rd` = 41200000, `resp_nx` = 0, `resp_err` = 0, `grant_id` = 0.
- **Contention.** All four ports hold `req_valid` continuously from reset.
  - Required: grants in order 0, 1, 2, 3, 0, and each response appears only on the matching port.
- **Response back-pressure.** Hold `resp_ready[1]` low for 10 cycles while port 2 is waiting.
  - Required: `resp_valid[1]` and `resp_rd` stay stable, and `req_ready[2]` stays 0 until the cycle after `resp_ready[1]` rises.
- **Watchdog.** A stub FMA unit never asserts done.
  - Required: with TIMEOUT = 64, `resp_valid` rises 64 cycles after `fma_start`, with `resp_rd` = 7FC00000 and `resp_err` = 1.
- **Stale done and reset abort.**
  - With `fma_done` held high during ISSUE, it must be ignored during ISSUE; the FSM advances only on `fma_done` sampled in WAIT.
  - Asserting `rst` during WAIT must return all outputs to 0 immediately, and a request issued after reset is granted to port 0.
